// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receiver files.
//   UART_DATA_W / UART_PRESC_W : default frame data width and Prescale width
//   BIT_CNT_W                  : width of the in-frame bit index (start..stop <= 10)
//   PRESC_8/16/32              : supported oversampling ratios
//   rx_state_e                 : receiver FSM states
//   maj3                       : 2-of-3 majority vote
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int UART_PRESC_W = 6;
    localparam int BIT_CNT_W    = 4;

    localparam logic [UART_PRESC_W-1:0] PRESC_8  = 6'd8;
    localparam logic [UART_PRESC_W-1:0] PRESC_16 = 6'd16;
    localparam logic [UART_PRESC_W-1:0] PRESC_32 = 6'd32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: bit timing and 3-sample majority vote for the UART receiver.
//   clk, rst        : clock, synchronous active-high reset
//   enable_i        : counters run while high, are held at 0 while low
//   prescale_i      : oversampling ratio P for the current frame
//   rx_i            : serial line
//   sampled_bit_o   : majority of the samples at edge P/2-1, P/2, P/2+1
//   sample_done_o   : high in the cycle of the third sample (sampled_bit_o valid)
//   bit_end_o       : high on the last oversample of a bit (edge_cnt = P-1)
//   bit_cnt_o       : index of the current bit within the frame
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = UART_PRESC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  rx_i,
    output logic                  sampled_bit_o,
    output logic                  sample_done_o,
    output logic                  bit_end_o,
    output logic [BIT_CNT_W-1:0]  bit_cnt_o
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  s0_q, s0_d, s1_q, s1_d;
    logic [PRESCALE_W-1:0] half;

    assign half          = prescale_i >> 1;
    assign bit_end_o     = (edge_cnt_q == prescale_i - ONE);
    // The third sample is taken straight off the line so the FSM can act on
    // the vote in the same cycle instead of one cycle later.
    assign sample_done_o = (edge_cnt_q == half + ONE);
    assign sampled_bit_o = maj3(s0_q, s1_q, rx_i);
    assign bit_cnt_o     = bit_cnt_q;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        if (!enable_i) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (bit_end_o) begin
            edge_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 1'b1;
        end else begin
            edge_cnt_d = edge_cnt_q + ONE;
        end
        if (edge_cnt_q == half - ONE) s0_d = rx_i;
        if (edge_cnt_q == half)       s1_d = rx_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
        end
    end

endmodule

// File: rtl/uart_rx_top.sv
// uart_rx_top: UART receiver (start, DATA_WIDTH data bits LSB-first, optional
// parity, one stop bit), oversampled by Prescale with a 3-sample majority vote.
//   clk, rst      : oversampling clock, synchronous active-high reset
//   RX_IN         : serial line, idle high, already synchronised
//   Prescale      : oversampling ratio (8/16/32), latched at start detect
//   Par_EN/Par_TYP: parity enable / odd(1) or even(0), latched at start detect
//   P_DATA        : last good byte
//   P_DATA_Valid  : 1-cycle pulse, P_DATA updated
//   par_err       : 1-cycle pulse, parity mismatch
//   stp_err       : 1-cycle pulse, stop bit was 0
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_W,
    parameter int PRESCALE_W = UART_PRESC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  Par_EN,
    input  logic                  Par_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  P_DATA_Valid,
    output logic                  par_err,
    output logic                  stp_err
);

    rx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d, presc_use;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, p_data_q, p_data_d;
    logic                  par_flag_q, par_flag_d, stp_flag_q, stp_flag_d;

    logic                  start_det, smp_en;
    logic                  sampled_bit, sample_done, bit_end;
    logic [BIT_CNT_W-1:0]  bit_cnt;

    assign start_det = (state_q == ST_IDLE) && !RX_IN;
    // The start-detect cycle is edge 0 of bit 0, before presc_q is loaded.
    assign presc_use = (state_q == ST_IDLE) ? Prescale : presc_q;
    // Counters run only while the next state is inside a frame, so they are
    // back at 0 for the next start whatever way the frame ended.
    assign smp_en    = state_d inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (smp_en),
        .prescale_i   (presc_use),
        .rx_i         (RX_IN),
        .sampled_bit_o(sampled_bit),
        .sample_done_o(sample_done),
        .bit_end_o    (bit_end),
        .bit_cnt_o    (bit_cnt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!RX_IN) state_d = ST_START;
            ST_START: begin
                if (sample_done && sampled_bit) state_d = ST_IDLE;  // glitch
                else if (bit_end)               state_d = ST_DATA;
            end
            ST_DATA:   if (bit_end && bit_cnt == BIT_CNT_W'(DATA_WIDTH))
                           state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (sample_done) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        P_DATA_Valid = 1'b0;
        par_err      = 1'b0;
        stp_err      = 1'b0;
        if (state_q == ST_DONE) begin
            P_DATA_Valid = !par_flag_q && !stp_flag_q;
            par_err      = par_flag_q;
            stp_err      = stp_flag_q;
        end
    end

    assign P_DATA = p_data_q;

    // Deserialiser, frame config latch, parity and stop checks
    always_comb begin
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        data_d     = data_q;
        par_flag_d = par_flag_q;
        stp_flag_d = stp_flag_q;
        p_data_d   = p_data_q;
        if (start_det) begin
            presc_d    = Prescale;
            par_en_d   = Par_EN;
            par_typ_d  = Par_TYP;
            par_flag_d = 1'b0;
            stp_flag_d = 1'b0;
        end
        if (sample_done) begin
            case (state_q)
                ST_DATA:   data_d = {sampled_bit, data_q[DATA_WIDTH-1:1]};
                ST_PARITY: par_flag_d = sampled_bit != ((^data_q) ^ par_typ_q);
                ST_STOP: begin
                    stp_flag_d = !sampled_bit;
                    // Loaded here so P_DATA is already new when the DONE pulse fires.
                    if (sampled_bit && !par_flag_q) p_data_d = data_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= PRESC_8;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            data_q     <= '0;
            par_flag_q <= 1'b0;
            stp_flag_q <= 1'b0;
            p_data_q   <= '0;
        end else begin
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            data_q     <= data_d;
            par_flag_q <= par_flag_d;
            stp_flag_q <= stp_flag_d;
            p_data_q   <= p_data_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: drives UART frames (optionally noisy, with bad parity or
// stop) and compares every observed output pulse against a frame-level model.
module tb_uart_rx_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       Par_EN, Par_TYP;
    logic [7:0] P_DATA;
    logic       P_DATA_Valid, par_err, stp_err;

    uart_rx_top dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .Prescale(Prescale),
        .Par_EN(Par_EN), .Par_TYP(Par_TYP), .P_DATA(P_DATA),
        .P_DATA_Valid(P_DATA_Valid), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       cyc;
        bit       v;
        bit       pe;
        bit       se;
        bit [7:0] d;
    } ev_t;

    ev_t      exp_q[$];
    ev_t      obs_q[$];
    int       n_cmp = 0;
    int       n_err = 0;
    bit [7:0] last_good = 8'h00;

    // Log every output pulse with its cycle stamp.
    always @(negedge clk) begin
        ev_t ev;
        if (P_DATA_Valid === 1'b1 || par_err === 1'b1 || stp_err === 1'b1) begin
            ev.cyc = cyc;
            ev.v   = P_DATA_Valid;
            ev.pe  = par_err;
            ev.se  = stp_err;
            ev.d   = P_DATA;
            obs_q.push_back(ev);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            RX_IN = 1'b1;
        end
    endtask

    function automatic int rand_p();
        int r;
        r = $urandom_range(0, 2);
        return (r == 0) ? 8 : (r == 1) ? 16 : 32;
    endfunction

    // Drive one frame. cut > 0 stops after that many cycles (no result expected).
    // Noise flips one of the three voted samples of every bit.
    task automatic send_frame(input int p, input bit pen, input bit ptyp, input bit [7:0] data,
                              input bit bad_par, input bit stop_v, input bit noise, input int cut);
        bit  bits[0:10];
        int  npos[0:10];
        int  nb, start, len, b, e;
        bit  v, perr, serr;
        ev_t ev;
        bits[0] = 1'b0;
        for (int j = 0; j < 8; j++) bits[j+1] = data[j];
        nb       = pen ? 11 : 10;
        bits[9]  = pen ? ((^data) ^ ptyp ^ bad_par) : stop_v;
        bits[10] = stop_v;
        for (int j = 0; j < 11; j++) npos[j] = $urandom_range(0, 2);
        len   = (cut > 0) ? cut : nb * p;
        start = 0;
        for (int i = 0; i < len; i++) begin
            tick();
            if (i == 0) begin
                Prescale = 6'(p);
                Par_EN   = pen;
                Par_TYP  = ptyp;
                start    = cyc;
            end else if (i == p) begin
                // Config must be latched: scramble it during the data bits.
                Prescale = 6'(rand_p());
                Par_EN   = 1'($urandom);
                Par_TYP  = 1'($urandom);
            end else if (i == (nb - 1) * p) begin
                Prescale = 6'(p);
                Par_EN   = pen;
                Par_TYP  = ptyp;
            end
            b = i / p;
            e = i % p;
            v = bits[b];
            if (noise && e == p / 2 - 1 + npos[b]) v = ~v;
            RX_IN = v;
        end
        if (cut == 0) begin
            perr = pen && bad_par;
            serr = !stop_v;
            ev.v  = !perr && !serr;
            ev.pe = perr;
            ev.se = serr;
            if (ev.v) last_good = data;
            ev.d   = last_good;
            ev.cyc = start + (nb - 1) * p + p / 2 + 2;
            exp_q.push_back(ev);
        end
    endtask

    task automatic check_events(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
            check({tag, "_valid"}, obs_q[i].v,   exp_q[i].v);
            check({tag, "_par"},   obs_q[i].pe,  exp_q[i].pe);
            check({tag, "_stp"},   obs_q[i].se,  exp_q[i].se);
            check({tag, "_data"},  obs_q[i].d,   exp_q[i].d);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_P_DATA"}, P_DATA, 0);
        check({tag, "_valid"},  P_DATA_Valid, 0);
        check({tag, "_par"},    par_err, 0);
        check({tag, "_stp"},    stp_err, 0);
    endtask

    initial begin
        int p;
        bit pen, bp, sv;
        rst      = 1'b1;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        Par_EN   = 1'b0;
        Par_TYP  = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        tick();
        rst = 1'b0;
        idle(4);

        // 1: P=8, no parity, 0xA5, 78-cycle latency
        send_frame(8, 0, 0, 8'hA5, 0, 1, 0, 0);
        idle(16);
        check_events("t1");

        // 2: P=16 even parity, good then bad parity
        send_frame(16, 1, 0, 8'h3C, 0, 1, 0, 0);
        idle(32);
        send_frame(16, 1, 0, 8'h3C, 1, 1, 0, 0);
        idle(32);
        check_events("t2");

        // 3: P=32 odd parity, stop bit 0
        send_frame(32, 1, 1, 8'h01, 0, 0, 0, 0);
        idle(64);
        check_events("t3");

        // 4: 2-cycle start glitch, then a good frame
        tick();
        Prescale = 6'd16;
        RX_IN    = 1'b0;
        tick();
        RX_IN    = 1'b0;
        idle(40);
        check_events("t4_glitch");
        send_frame(16, 0, 0, 8'h5A, 0, 1, 0, 0);
        idle(32);
        check_events("t4");

        // 5: back-to-back frames, then back-to-back noisy frames
        send_frame(8, 1, 0, 8'hFF, 0, 1, 0, 0);
        send_frame(8, 1, 0, 8'h00, 0, 1, 0, 0);
        idle(16);
        check_events("t5");
        send_frame(8, 1, 1, 8'($urandom), 0, 1, 1, 0);
        send_frame(8, 1, 0, 8'($urandom), 0, 1, 1, 0);
        idle(16);
        check_events("t5_noise");

        // 6: reset in the middle of the data bits
        send_frame(16, 0, 0, 8'h77, 0, 1, 0, 0);
        idle(32);
        check_events("t6_pre");
        send_frame(16, 0, 0, 8'hC3, 0, 1, 0, 5 * 16);
        tick();
        rst   = 1'b1;
        RX_IN = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("t6_rst");
        tick();
        rst       = 1'b0;
        last_good = 8'h00;
        idle(8);
        check_events("t6_abort");
        send_frame(16, 0, 0, 8'h81, 0, 1, 0, 0);
        idle(32);
        check_events("t6");

        // Random frames
        for (int k = 0; k < 20; k++) begin
            p   = rand_p();
            pen = 1'($urandom);
            bp  = pen && ($urandom_range(0, 3) == 0);
            sv  = ($urandom_range(0, 7) != 0);
            send_frame(p, pen, 1'($urandom), 8'($urandom), bp, sv, 1'($urandom), 0);
            idle(2 * p);
            check_events("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
